// File: rtl/x86_length_decoder.sv
// x86_length_decoder: combinational x86-64 instruction length decoder.
// Examines a 15-byte window (byte 0 in the top bits) and reports the
// length and fields of the leading instruction. A registered counter
// tallies the cycles in which a supported instruction was decoded.
module x86_length_decoder (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [119:0] bytes,
    output logic [3:0]   len,
    output logic         ok,
    output logic [7:0]   opcode,
    output logic         two_byte,
    output logic         has_modrm,
    output logic [2:0]   disp_len,
    output logic [3:0]   imm_len,
    output logic [3:0]   prefix_cnt,
    output logic         rex_w,
    output logic [31:0]  inst_count
);
    localparam int WIN = 15;

    // Byte k of the window; positions at or past the window end read as 00.
    // Any field landing there pushes the total past 15, so the value is moot.
    function automatic logic [7:0] win_byte(input logic [119:0] w, input logic [5:0] k);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 0; i < WIN; i++) begin
            if (k == 6'(i)) b = w[119-8*i -: 8];
        end
        return b;
    endfunction

    function automatic logic is_prefix(input logic [7:0] b);
        logic p;
        case (b)
            8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
            8'h26, 8'h64, 8'h65, 8'h66, 8'h67: p = 1'b1;
            default:                            p = 1'b0;
        endcase
        return p;
    endfunction

    logic [3:0]  w_pcnt;
    logic        w_osz16;
    logic [7:0]  w_rex_byte;
    logic        w_rex;
    logic        w_w;
    logic [5:0]  w_opos;
    logic [7:0]  w_b0;
    logic        w_esc;
    logic [7:0]  w_opc;
    logic [5:0]  w_mpos;
    logic [7:0]  w_modrm;
    logic [7:0]  w_sib;
    logic [3:0]  w_immz;
    logic        w_valid;
    logic        w_need_modrm;
    logic [3:0]  w_imm;
    logic        w_has_sib;
    logic [2:0]  w_disp;
    logic [5:0]  w_total;
    logic        w_ok;
    logic [31:0] r_inst_count;

    // Count the leading run of legacy prefixes and note whether 66 is in it.
    always_comb begin
        logic w_run;
        w_run   = 1'b1;
        w_pcnt  = 4'd0;
        w_osz16 = 1'b0;
        for (int i = 0; i < WIN; i++) begin
            if (w_run && is_prefix(bytes[119-8*i -: 8])) begin
                w_pcnt = w_pcnt + 4'd1;
                if (bytes[119-8*i -: 8] == 8'h66) w_osz16 = 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // A REX byte is only recognised directly after the prefix run.
    assign w_rex_byte = win_byte(bytes, {2'b00, w_pcnt});
    assign w_rex      = (w_pcnt < 4'd15) && ((w_rex_byte & 8'hF0) == 8'h40);
    assign w_w        = w_rex && w_rex_byte[3];
    assign w_opos     = {2'b00, w_pcnt} + {5'd0, w_rex};
    assign w_b0       = win_byte(bytes, w_opos);
    assign w_esc      = (w_b0 == 8'h0F);
    assign w_opc      = w_esc ? win_byte(bytes, w_opos + 6'd1) : w_b0;
    assign w_mpos     = w_opos + (w_esc ? 6'd2 : 6'd1);
    assign w_modrm    = win_byte(bytes, w_mpos);
    assign w_sib      = win_byte(bytes, w_mpos + 6'd1);
    // REX.W overrides the 66 operand-size prefix.
    assign w_immz     = (w_osz16 && !w_w) ? 4'd2 : 4'd4;

    // Classify the opcode: supported or not, ModRM presence, immediate size.
    always_comb begin
        w_valid      = 1'b1;
        w_need_modrm = 1'b0;
        w_imm        = 4'd0;
        if (w_esc) begin
            case (w_opc) inside
                8'h05, 8'h0B, 8'hA2: begin
                end
                [8'h10:8'h17], 8'h1F, [8'h28:8'h2F], [8'h40:8'h4F], [8'h90:8'h9F],
                8'hAF, 8'hB6, 8'hB7, 8'hBE, 8'hBF:
                    w_need_modrm = 1'b1;
                [8'h80:8'h8F]:
                    w_imm = 4'd4;
                default:
                    w_valid = 1'b0;
            endcase
        end else begin
            case (w_opc) inside
                8'h27, 8'h2F, 8'h37, 8'h3F:
                    w_valid = 1'b0;
                [8'h00:8'h3F]: begin
                    case (w_opc[2:0])
                        3'd0, 3'd1, 3'd2, 3'd3: w_need_modrm = 1'b1;
                        3'd4:                   w_imm = 4'd1;
                        3'd5:                   w_imm = w_immz;
                        default:                w_valid = 1'b0;
                    endcase
                end
                [8'h50:8'h5F], [8'h90:8'h99], 8'h9C, 8'h9D, 8'hC3, 8'hC9, 8'hCC, 8'hF4: begin
                end
                8'h63, [8'h84:8'h8F], [8'hD0:8'hD3], 8'hFE, 8'hFF:
                    w_need_modrm = 1'b1;
                8'h68, 8'hA9:
                    w_imm = w_immz;
                8'h69, 8'h81, 8'hC7: begin
                    w_need_modrm = 1'b1;
                    w_imm        = w_immz;
                end
                8'h6A, [8'h70:8'h7F], 8'hEB, 8'hA8, [8'hB0:8'hB7], 8'hCD:
                    w_imm = 4'd1;
                8'h6B, 8'h80, 8'h83, 8'hC0, 8'hC1, 8'hC6: begin
                    w_need_modrm = 1'b1;
                    w_imm        = 4'd1;
                end
                8'hC2:
                    w_imm = 4'd2;
                8'hE8, 8'hE9:
                    w_imm = 4'd4;
                [8'hB8:8'hBF]:
                    w_imm = w_w ? 4'd8 : w_immz;
                8'hF6: begin
                    w_need_modrm = 1'b1;
                    w_imm        = (w_modrm[5:3] < 3'd2) ? 4'd1 : 4'd0;
                end
                8'hF7: begin
                    w_need_modrm = 1'b1;
                    w_imm        = (w_modrm[5:3] < 3'd2) ? w_immz : 4'd0;
                end
                default:
                    w_valid = 1'b0;
            endcase
        end
    end

    // Decode ModRM addressing into SIB presence and displacement size.
    always_comb begin
        w_has_sib = 1'b0;
        w_disp    = 3'd0;
        if (w_need_modrm && (w_modrm[7:6] != 2'b11)) begin
            w_has_sib = (w_modrm[2:0] == 3'b100);
            case (w_modrm[7:6])
                2'b00: begin
                    // disp32 with no base: SIB.base=101, or RIP-relative rm=101.
                    if (w_has_sib ? ((w_sib & 8'h07) == 8'h05) : (w_modrm[2:0] == 3'b101))
                        w_disp = 3'd4;
                end
                2'b01:   w_disp = 3'd1;
                default: w_disp = 3'd4;
            endcase
        end
    end

    assign w_total = w_mpos + {5'd0, w_need_modrm} + {5'd0, w_has_sib}
                   + {3'd0, w_disp} + {2'd0, w_imm};
    assign w_ok    = reset && in_valid && w_valid && (w_total <= 6'd15);

    assign ok         = w_ok;
    assign len        = w_ok ? w_total[3:0] : 4'd0;
    assign opcode     = w_opc;
    assign two_byte   = w_esc;
    assign has_modrm  = w_need_modrm;
    assign disp_len   = w_disp;
    assign imm_len    = w_imm;
    assign prefix_cnt = w_pcnt;
    assign rex_w      = w_w;
    assign inst_count = r_inst_count;

    // Retired-instruction counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inst_count <= 32'd0;
        end else if (w_ok) begin
            r_inst_count <= r_inst_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_x86_length_decoder.sv
// Self-checking bench for x86_length_decoder: directed vectors, randomized
// windows against a table-driven reference model, and counter behaviour.
module tb_x86_length_decoder;
    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic [119:0] bytes = '0;
    logic [3:0]   len;
    logic         ok;
    logic [7:0]   opcode;
    logic         two_byte;
    logic         has_modrm;
    logic [2:0]   disp_len;
    logic [3:0]   imm_len;
    logic [3:0]   prefix_cnt;
    logic         rex_w;
    logic [31:0]  inst_count;

    int n_checks = 0;
    int n_pass   = 0;

    x86_length_decoder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .bytes(bytes),
        .len(len), .ok(ok), .opcode(opcode), .two_byte(two_byte),
        .has_modrm(has_modrm), .disp_len(disp_len), .imm_len(imm_len),
        .prefix_cnt(prefix_cnt), .rex_w(rex_w), .inst_count(inst_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d passed=%0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

    // Opcode operand classes for the reference model.
    localparam int C_BAD = 0, C_NONE = 1, C_M = 2, C_I8 = 3, C_IZ = 4, C_MI8 = 5,
                   C_MIZ = 6, C_I16 = 7, C_I32 = 8, C_MOVI = 9, C_F6 = 10, C_F7 = 11;
    int cls1[256];
    int cls2[256];
    logic [7:0] pfx_list[11] = '{8'hF0, 8'hF2, 8'hF3, 8'h2E, 8'h36, 8'h3E,
                                 8'h26, 8'h64, 8'h65, 8'h66, 8'h67};

    typedef struct {
        int         len;
        bit         ok;
        int         pc;
        bit         two;
        bit         modrm;
        int         disp;
        int         imm;
        bit         w;
        logic [7:0] op;
    } exp_t;

    task automatic set1(input int lo, input int hi, input int c);
        for (int i = lo; i <= hi; i++) cls1[i] = c;
    endtask

    task automatic set2(input int lo, input int hi, input int c);
        for (int i = lo; i <= hi; i++) cls2[i] = c;
    endtask

    task automatic build_tables();
        for (int i = 0; i < 256; i++) begin
            cls1[i] = C_BAD;
            cls2[i] = C_BAD;
        end
        for (int i = 0; i < 64; i++) begin
            if (i % 8 < 4)       cls1[i] = C_M;
            else if (i % 8 == 4) cls1[i] = C_I8;
            else if (i % 8 == 5) cls1[i] = C_IZ;
        end
        set1('h50, 'h5F, C_NONE); set1('h90, 'h99, C_NONE);
        set1('h9C, 'h9D, C_NONE); set1('hC3, 'hC3, C_NONE); set1('hC9, 'hC9, C_NONE);
        set1('hCC, 'hCC, C_NONE); set1('hF4, 'hF4, C_NONE);
        set1('h63, 'h63, C_M); set1('h84, 'h8F, C_M); set1('hD0, 'hD3, C_M);
        set1('hFE, 'hFF, C_M);
        set1('h68, 'h68, C_IZ); set1('h69, 'h69, C_MIZ); set1('h6A, 'h6A, C_I8);
        set1('h6B, 'h6B, C_MI8); set1('h70, 'h7F, C_I8); set1('hEB, 'hEB, C_I8);
        set1('h80, 'h80, C_MI8); set1('h83, 'h83, C_MI8); set1('hC0, 'hC1, C_MI8);
        set1('hC6, 'hC6, C_MI8); set1('h81, 'h81, C_MIZ); set1('hC7, 'hC7, C_MIZ);
        set1('hA8, 'hA8, C_I8); set1('hB0, 'hB7, C_I8); set1('hCD, 'hCD, C_I8);
        set1('hA9, 'hA9, C_IZ); set1('hC2, 'hC2, C_I16); set1('hE8, 'hE9, C_I32);
        set1('hB8, 'hBF, C_MOVI); set1('hF6, 'hF6, C_F6); set1('hF7, 'hF7, C_F7);
        set2('h05, 'h05, C_NONE); set2('h0B, 'h0B, C_NONE); set2('hA2, 'hA2, C_NONE);
        set2('h10, 'h17, C_M); set2('h1F, 'h1F, C_M); set2('h28, 'h2F, C_M);
        set2('h40, 'h4F, C_M); set2('h90, 'h9F, C_M); set2('hAF, 'hAF, C_M);
        set2('hB6, 'hB7, C_M); set2('hBE, 'hBF, C_M); set2('h80, 'h8F, C_I32);
    endtask

    function automatic bit is_pfx(input logic [7:0] b);
        for (int i = 0; i < 11; i++) if (pfx_list[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    // Walk the window byte by byte, consuming fields in order.
    function automatic exp_t model(input logic [119:0] win, input bit iv);
        exp_t e;
        logic [7:0] b[15];
        logic [7:0] m, s;
        int pos, c, immz, total;
        bit o16, bad;
        for (int k = 0; k < 15; k++) b[k] = win[119-8*k -: 8];
        e.len = 0; e.ok = 0; e.pc = 0; e.two = 0; e.modrm = 0;
        e.disp = 0; e.imm = 0; e.w = 0; e.op = 8'h00;
        pos = 0; o16 = 0; bad = 0; m = 8'h00; s = 8'h00;
        while (pos < 15 && is_pfx(b[pos])) begin
            if (b[pos] == 8'h66) o16 = 1;
            pos++;
        end
        e.pc = pos;
        if (pos < 15 && b[pos][7:4] == 4'h4) begin
            e.w = b[pos][3];
            pos++;
        end
        if (pos >= 15) bad = 1;
        else begin
            e.op = b[pos];
            pos++;
            if (e.op == 8'h0F) begin
                e.two = 1;
                if (pos >= 15) bad = 1;
                else begin
                    e.op = b[pos];
                    pos++;
                end
            end
        end
        c = bad ? C_BAD : (e.two ? cls2[e.op] : cls1[e.op]);
        immz = (o16 && !e.w) ? 2 : 4;
        e.modrm = c inside {C_M, C_MI8, C_MIZ, C_F6, C_F7};
        if (!bad && e.modrm) begin
            if (pos >= 15) bad = 1;
            else begin
                m = b[pos];
                pos++;
                if (m[7:6] != 2'b11) begin
                    if (m[2:0] == 3'd4) begin
                        if (pos >= 15) bad = 1;
                        else begin
                            s = b[pos];
                            pos++;
                        end
                    end
                    if (m[7:6] == 2'b01) e.disp = 1;
                    else if (m[7:6] == 2'b10) e.disp = 4;
                    else if ((m[2:0] == 3'd4) ? (s[2:0] == 3'd5) : (m[2:0] == 3'd5)) e.disp = 4;
                end
            end
        end
        case (c)
            C_I8, C_MI8:  e.imm = 1;
            C_IZ, C_MIZ:  e.imm = immz;
            C_I16:        e.imm = 2;
            C_I32:        e.imm = 4;
            C_MOVI:       e.imm = e.w ? 8 : immz;
            C_F6:         e.imm = (m[5:3] < 2) ? 1 : 0;
            C_F7:         e.imm = (m[5:3] < 2) ? immz : 0;
            default:      e.imm = 0;
        endcase
        total = pos + e.disp + e.imm;
        e.ok  = iv && !bad && (c != C_BAD) && (total <= 15);
        e.len = e.ok ? total : 0;
        return e;
    endfunction

    task automatic drive(input logic [119:0] w, input bit iv);
        @(negedge clk);
        bytes    = w;
        in_valid = iv;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bytes = {24'h4889E5, 96'h0};
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (inst_count !== 32'd0) $display("FAIL reset_count got %0d exp 0", inst_count); else n_pass++;
        n_checks++; if (ok !== 1'b0) $display("FAIL reset_ok got %b exp 0", ok); else n_pass++;
        n_checks++; if (len !== 4'd0) $display("FAIL reset_len got %0d exp 0", len); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (ok !== 1'b1 || len !== 4'd3) $display("FAIL reset_release ok=%b len=%0d exp ok=1 len=3", ok, len); else n_pass++;
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        drive({24'h4889E5, 96'h0}, 1'b1);
        n_checks++; if (len !== 4'd3) $display("FAIL basic_len got %0d exp 3", len); else n_pass++;
        n_checks++; if (ok !== 1'b1) $display("FAIL basic_ok got %b exp 1", ok); else n_pass++;
        n_checks++; if (rex_w !== 1'b1) $display("FAIL basic_rexw got %b exp 1", rex_w); else n_pass++;
        n_checks++; if (has_modrm !== 1'b1) $display("FAIL basic_modrm got %b exp 1", has_modrm); else n_pass++;
        n_checks++; if (disp_len !== 3'd0 || imm_len !== 4'd0) $display("FAIL basic_dispimm got %0d/%0d exp 0/0", disp_len, imm_len); else n_pass++;
    endtask

    task automatic test_immediates();
        drive({80'h48B8_1122334455667788, 40'h0}, 1'b1);
        n_checks++; if (len !== 4'd10) $display("FAIL movabs_len got %0d exp 10", len); else n_pass++;
        n_checks++; if (imm_len !== 4'd8) $display("FAIL movabs_imm got %0d exp 8", imm_len); else n_pass++;
        drive({32'h66B83412, 88'h0}, 1'b1);
        n_checks++; if (len !== 4'd4) $display("FAIL mov16_len got %0d exp 4", len); else n_pass++;
        n_checks++; if (imm_len !== 4'd2) $display("FAIL mov16_imm got %0d exp 2", imm_len); else n_pass++;
        n_checks++; if (prefix_cnt !== 4'd1) $display("FAIL mov16_pcnt got %0d exp 1", prefix_cnt); else n_pass++;
    endtask

    task automatic test_addressing();
        drive({32'h8B442408, 88'h0}, 1'b1);
        n_checks++; if (len !== 4'd4 || disp_len !== 3'd1) $display("FAIL sib_disp8 len=%0d disp=%0d exp 4/1", len, disp_len); else n_pass++;
        drive({48'h8B05_11223344, 72'h0}, 1'b1);
        n_checks++; if (len !== 4'd6 || disp_len !== 3'd4) $display("FAIL rip_rel len=%0d disp=%0d exp 6/4", len, disp_len); else n_pass++;
        drive({56'h8B0425_11223344, 64'h0}, 1'b1);
        n_checks++; if (len !== 4'd7 || disp_len !== 3'd4) $display("FAIL sib_base101 len=%0d disp=%0d exp 7/4", len, disp_len); else n_pass++;
    endtask

    task automatic test_branches();
        drive({48'h0F84_10203040, 72'h0}, 1'b1);
        n_checks++; if (len !== 4'd6) $display("FAIL jcc32_len got %0d exp 6", len); else n_pass++;
        n_checks++; if (two_byte !== 1'b1 || opcode !== 8'h84) $display("FAIL jcc32_op two=%b op=%h exp 1/84", two_byte, opcode); else n_pass++;
        drive({40'hE8_01020304, 80'h0}, 1'b1);
        n_checks++; if (len !== 4'd5) $display("FAIL call_len got %0d exp 5", len); else n_pass++;
        drive({16'hF7D0, 104'h0}, 1'b1);
        n_checks++; if (len !== 4'd2) $display("FAIL not_len got %0d exp 2", len); else n_pass++;
        drive({40'h66F7C03412, 80'h0}, 1'b1);
        n_checks++; if (len !== 4'd5 || imm_len !== 4'd2) $display("FAIL test16 len=%0d imm=%0d exp 5/2", len, imm_len); else n_pass++;
    endtask

    task automatic test_failures();
        drive({16'h0F0F, 104'h0}, 1'b1);
        n_checks++; if (ok !== 1'b0 || len !== 4'd0) $display("FAIL bad_0f0f ok=%b len=%0d exp 0/0", ok, len); else n_pass++;
        drive({{14{8'h66}}, 8'h05}, 1'b1);
        n_checks++; if (ok !== 1'b0 || len !== 4'd0) $display("FAIL too_long ok=%b len=%0d exp 0/0", ok, len); else n_pass++;
        n_checks++; if (prefix_cnt !== 4'd14) $display("FAIL too_long_pcnt got %0d exp 14", prefix_cnt); else n_pass++;
        drive({24'h4889E5, 96'h0}, 1'b0);
        n_checks++; if (ok !== 1'b0 || len !== 4'd0) $display("FAIL no_valid ok=%b len=%0d exp 0/0", ok, len); else n_pass++;
    endtask

    task automatic test_random(input int n);
        exp_t e;
        logic [7:0] b[15];
        logic [119:0] win;
        int np, pos;
        bit iv;
        for (int t = 0; t < n; t++) begin
            for (int k = 0; k < 15; k++) b[k] = 8'($urandom);
            np = ($urandom_range(0, 15) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 3));
            for (int k = 0; k < np; k++) b[k] = pfx_list[$urandom_range(0, 10)];
            pos = np;
            if (pos < 15 && $urandom_range(0, 1) == 1) begin
                b[pos] = 8'h40 | 8'($urandom_range(0, 15));
                pos++;
            end
            if (pos < 14 && $urandom_range(0, 3) == 0) begin
                b[pos] = 8'h0F;
                for (int r = 0; r < 6; r++) begin
                    b[pos+1] = 8'($urandom_range(0, 255));
                    if (cls2[b[pos+1]] != C_BAD) break;
                end
            end else if (pos < 15 && $urandom_range(0, 4) != 0) begin
                for (int r = 0; r < 6; r++) begin
                    b[pos] = 8'($urandom_range(0, 255));
                    if (cls1[b[pos]] != C_BAD) break;
                end
            end
            for (int k = 0; k < 15; k++) win[119-8*k -: 8] = b[k];
            iv = ($urandom_range(0, 9) != 0);
            drive(win, iv);
            e = model(win, iv);
            n_checks++; if (len !== 4'(e.len)) $display("FAIL rand_len win=%h got %0d exp %0d", win, len, e.len); else n_pass++;
            n_checks++; if (ok !== e.ok) $display("FAIL rand_ok win=%h got %b exp %b", win, ok, e.ok); else n_pass++;
            n_checks++; if (prefix_cnt !== 4'(e.pc)) $display("FAIL rand_pcnt win=%h got %0d exp %0d", win, prefix_cnt, e.pc); else n_pass++;
            if (e.ok) begin
                n_checks++;
                if ({opcode, two_byte, has_modrm, disp_len, imm_len, rex_w} !==
                    {e.op, e.two, e.modrm, 3'(e.disp), 4'(e.imm), e.w})
                    $display("FAIL rand_fields win=%h got op=%h two=%b m=%b d=%0d i=%0d w=%b exp op=%h two=%b m=%b d=%0d i=%0d w=%b",
                             win, opcode, two_byte, has_modrm, disp_len, imm_len, rex_w,
                             e.op, e.two, e.modrm, e.disp, e.imm, e.w);
                else n_pass++;
            end
        end
    endtask

    task automatic test_counter();
        @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (inst_count !== 32'd0) $display("FAIL cnt_clear got %0d exp 0", inst_count); else n_pass++;
        @(negedge clk);
        bytes = {24'h4889E5, 96'h0};
        in_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (inst_count !== 32'd5) $display("FAIL cnt_five got %0d exp 5", inst_count); else n_pass++;
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if (inst_count !== 32'd0) $display("FAIL cnt_async_clear got %0d exp 0", inst_count); else n_pass++;
        n_checks++; if (ok !== 1'b0 || len !== 4'd0) $display("FAIL cnt_reset_outs ok=%b len=%0d exp 0/0", ok, len); else n_pass++;
        @(posedge clk);
        #1;
        n_checks++; if (inst_count !== 32'd0) $display("FAIL cnt_reset_wins got %0d exp 0", inst_count); else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (inst_count !== 32'd1) $display("FAIL cnt_resume got %0d exp 1", inst_count); else n_pass++;
    endtask

    task automatic test_wrap();
        @(negedge clk);
        in_valid = 1'b0;
        force dut.r_inst_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_inst_count;
        #1;
        n_checks++; if (inst_count !== 32'hFFFF_FFFE) $display("FAIL wrap_preload got %h exp fffffffe", inst_count); else n_pass++;
        @(negedge clk);
        bytes = {40'hE8_01020304, 80'h0};
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        n_checks++; if (inst_count !== 32'hFFFF_FFFF) $display("FAIL wrap_max got %h exp ffffffff", inst_count); else n_pass++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_checks++; if (inst_count !== 32'd0) $display("FAIL wrap_zero got %h exp 0", inst_count); else n_pass++;
    endtask

    initial begin
        build_tables();
        test_reset();
        test_basic();
        test_immediates();
        test_addressing();
        test_branches();
        test_failures();
        test_random(400);
        test_counter();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
